// File: rtl/spi_responder.sv
// SPI mode-0 responder: 8-bit MSB-first full-duplex frames with a one-byte
// transmit holding register and a receive byte port with a valid pulse.
module spi_responder #(
    parameter logic [1:0]  SS_ID       = 2'd1,
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       sck_i,
    input  logic       mosi_i,
    input  logic [1:0] ss_i,
    output logic       miso_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_load_i,
    output logic       tx_full_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       tx_underrun_o,
    output logic       tx_overflow_o
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t      state;
    logic        sck_s;
    logic        mosi_s;
    logic [1:0]  ss_s;
    logic        sck_q;
    logic [7:0]  txsh;
    logic [7:0]  rxsh;
    logic [3:0]  bitcnt;
    logic [7:0]  hold;
    logic        tx_full;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pend;
    logic        tx_underrun;
    logic        tx_overflow;
    logic        sel;
    logic        rise;
    logic        fall;
    logic        frame_load;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign sck_s  = sck_i;
            assign mosi_s = mosi_i;
            assign ss_s   = ss_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0]      sck_pipe;
            logic [SYNC_STAGES-1:0]      mosi_pipe;
            logic [SYNC_STAGES-1:0][1:0] ss_pipe;

            always_ff @(posedge Clk_i or posedge Rst_i) begin
                if (Rst_i) begin
                    sck_pipe  <= '0;
                    mosi_pipe <= '0;
                    ss_pipe   <= '0;
                end else begin
                    sck_pipe[0]  <= sck_i;
                    mosi_pipe[0] <= mosi_i;
                    ss_pipe[0]   <= ss_i;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                        sck_pipe[i]  <= sck_pipe[i-1];
                        mosi_pipe[i] <= mosi_pipe[i-1];
                        ss_pipe[i]   <= ss_pipe[i-1];
                    end
                end
            end

            assign sck_s  = sck_pipe[SYNC_STAGES-1];
            assign mosi_s = mosi_pipe[SYNC_STAGES-1];
            assign ss_s   = ss_pipe[SYNC_STAGES-1];
        end
    endgenerate

    assign sel  = (ss_s == SS_ID);
    assign rise = sck_s & ~sck_q;
    assign fall = ~sck_s & sck_q;

    // A frame loads on first select, or on the trailing fall of a completed
    // byte while still selected (back-to-back frames).
    always_comb begin
        frame_load = 1'b0;
        if (sel) begin
            if (state == IDLE)
                frame_load = 1'b1;
            else if (fall && bitcnt == 4'd8)
                frame_load = 1'b1;
        end
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state       <= IDLE;
            sck_q       <= 1'b0;
            txsh        <= '0;
            rxsh        <= '0;
            bitcnt      <= '0;
            hold        <= '0;
            tx_full     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_pend     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            sck_q       <= sck_s;
            rx_valid    <= 1'b0;
            rx_pend     <= 1'b0;
            tx_underrun <= 1'b0;
            tx_overflow <= 1'b0;

            // A completed byte is delivered even if the frame was just deselected.
            if (rx_pend) begin
                rx_data  <= rxsh;
                rx_valid <= 1'b1;
            end

            if (frame_load) begin
                txsh        <= tx_full ? hold : 8'h00;
                tx_underrun <= ~tx_full;
                bitcnt      <= '0;
            end

            // A load coinciding with a frame load refills the register just emptied.
            if (tx_load_i) begin
                if (!tx_full || frame_load) begin
                    hold    <= tx_data_i;
                    tx_full <= 1'b1;
                end else begin
                    tx_overflow <= 1'b1;
                end
            end else if (frame_load) begin
                tx_full <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sel)
                        state <= ACTIVE;
                end
                ACTIVE: begin
                    if (!sel) begin
                        state  <= IDLE;
                        bitcnt <= '0;
                    end else if (rise && bitcnt != 4'd8) begin
                        rxsh   <= {rxsh[6:0], mosi_s};
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt == 4'd7)
                            rx_pend <= 1'b1;
                    end else if (fall && bitcnt != 4'd8) begin
                        txsh <= {txsh[6:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign miso_o        = (state == ACTIVE) & txsh[7];
    assign tx_full_o     = tx_full;
    assign rx_data_o     = rx_data;
    assign rx_valid_o    = rx_valid;
    assign tx_underrun_o = tx_underrun;
    assign tx_overflow_o = tx_overflow;

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: a mode-0 bus master model drives frames, expected
// receive bytes are queued and checked by a monitor on every rx_valid_o pulse.
module tb_spi_responder;

    logic       clk;
    logic       rst;
    logic       sck;
    logic       mosi;
    logic [1:0] ss;
    logic       miso;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_full;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       tx_overflow;

    int total = 0;
    int bad = 0;
    int rx_seen = 0;
    int und_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] rx_q[$];

    spi_responder #(.SS_ID(2'd1), .SYNC_STAGES(0)) dut (
        .Clk_i(clk),
        .Rst_i(rst),
        .sck_i(sck),
        .mosi_i(mosi),
        .ss_i(ss),
        .miso_o(miso),
        .tx_data_i(tx_data),
        .tx_load_i(tx_load),
        .tx_full_o(tx_full),
        .rx_data_o(rx_data),
        .rx_valid_o(rx_valid),
        .tx_underrun_o(tx_underrun),
        .tx_overflow_o(tx_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (rx_valid) begin
                rx_seen++;
                total++;
                if (rx_q.size() == 0) begin
                    bad++;
                    $display("FAIL rx_unexpected: got %02h required no rx_valid_o", rx_data);
                end else begin
                    logic [7:0] e;
                    e = rx_q.pop_front();
                    if (rx_data !== e) begin
                        bad++;
                        $display("FAIL rx_data: got %02h required %02h", rx_data, e);
                    end
                end
            end
            if (tx_underrun) und_cnt++;
            if (tx_overflow) ovf_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] b);
        tx_data = b;
        tx_load = 1'b1;
        wait_n(1);
        tx_load = 1'b0;
    endtask

    task automatic select(input logic [1:0] code);
        ss = code;
        wait_n(4);
    endtask

    task automatic deselect();
        ss = 2'd0;
        wait_n(6);
    endtask

    // Mode 0 master: MOSI set while SCK low, MISO sampled at the rising edge.
    task automatic frame(input logic [7:0] tx, input int nbits, input logic mid_load,
                         input logic [7:0] mid_byte, output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_n(4);
            sck = 1'b1;
            got = {got[6:0], miso};
            if (mid_load && i == 3) begin
                load(mid_byte);
                wait_n(3);
            end else begin
                wait_n(4);
            end
            sck = 1'b0;
            wait_n(4);
        end
        mosi = 1'b0;
    endtask

    initial begin
        logic [7:0] got;
        int r0, u0, o0;

        rst = 1'b1; sck = 1'b0; mosi = 1'b0; ss = 2'd0; tx_data = 8'h00; tx_load = 1'b0;
        wait_n(3);
        chk("reset_miso", miso, 0);
        chk("reset_tx_full", tx_full, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_pulses", {rx_valid, tx_underrun, tx_overflow}, 0);
        rst = 1'b0;
        wait_n(3);

        // single exchange
        r0 = rx_seen; u0 = und_cnt;
        load(8'hA5);
        chk("single_full_after_load", tx_full, 1);
        select(2'd1);
        chk("single_full_after_select", tx_full, 0);
        rx_q.push_back(8'h3C);
        frame(8'h3C, 8, 1'b0, 8'h00, got);
        chk("single_master_rx", got, 8'hA5);
        deselect();
        chk("single_rx_count", rx_seen - r0, 1);
        chk("single_underrun_count", und_cnt - u0, 1);

        // back-to-back frames with SS held
        r0 = rx_seen; u0 = und_cnt;
        load(8'h81);
        select(2'd1);
        rx_q.push_back(8'h12);
        rx_q.push_back(8'h34);
        frame(8'h12, 8, 1'b1, 8'h7E, got);
        chk("b2b_master_rx1", got, 8'h81);
        frame(8'h34, 8, 1'b0, 8'h00, got);
        chk("b2b_master_rx2", got, 8'h7E);
        deselect();
        chk("b2b_rx_count", rx_seen - r0, 2);
        chk("b2b_underrun_count", und_cnt - u0, 1);

        // underrun on select with empty holding register
        u0 = und_cnt;
        select(2'd1);
        chk("underrun_at_select", und_cnt - u0, 1);
        rx_q.push_back(8'h5A);
        frame(8'h5A, 8, 1'b0, 8'h00, got);
        chk("underrun_master_rx", got, 8'h00);
        deselect();

        // overflow: second load while full is dropped
        o0 = ovf_cnt;
        load(8'h11);
        load(8'h22);
        wait_n(1);
        chk("overflow_count", ovf_cnt - o0, 1);
        chk("overflow_full", tx_full, 1);
        select(2'd1);
        rx_q.push_back(8'h96);
        frame(8'h96, 8, 1'b0, 8'h00, got);
        chk("overflow_master_rx", got, 8'h11);
        deselect();

        // not selected: another SS code
        r0 = rx_seen; u0 = und_cnt;
        load(8'h77);
        select(2'd2);
        frame(8'hFF, 8, 1'b0, 8'h00, got);
        chk("unsel_master_rx", got, 8'h00);
        deselect();
        chk("unsel_rx_count", rx_seen - r0, 0);
        chk("unsel_full", tx_full, 1);
        chk("unsel_underrun", und_cnt - u0, 0);

        // abort after 5 rises, then a clean frame
        r0 = rx_seen;
        select(2'd1);
        chk("abort_full_cleared", tx_full, 0);
        frame(8'hAA, 5, 1'b0, 8'h00, got);
        chk("abort_partial_miso", got[4:0], 5'b01110);
        deselect();
        wait_n(4);
        chk("abort_rx_count", rx_seen - r0, 0);
        load(8'h3D);
        select(2'd1);
        rx_q.push_back(8'hC3);
        frame(8'hC3, 8, 1'b0, 8'h00, got);
        chk("reselect_master_rx", got, 8'h3D);
        deselect();
        chk("reselect_rx_data", rx_data, 8'hC3);

        // reset mid-frame
        r0 = rx_seen;
        load(8'h55);
        select(2'd1);
        frame(8'h0F, 3, 1'b0, 8'h00, got);
        load(8'h66);
        chk("pre_reset_full", tx_full, 1);
        rst = 1'b1;
        #1;
        chk("midreset_miso", miso, 0);
        chk("midreset_tx_full", tx_full, 0);
        chk("midreset_rx_data", rx_data, 0);
        ss = 2'd0; sck = 1'b0; mosi = 1'b0;
        wait_n(2);
        rst = 1'b0;
        wait_n(20);
        chk("post_reset_rx_count", rx_seen - r0, 0);
        load(8'h9C);
        select(2'd1);
        rx_q.push_back(8'hE7);
        frame(8'hE7, 8, 1'b0, 8'h00, got);
        chk("post_reset_master_rx", got, 8'h9C);
        deselect();

        wait_n(10);
        chk("rx_queue_drained", rx_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI responder (slave) for the team's SPI master. Sits on the far end of the SCK/MOSI/MISO/SS bus.
- Mode 0, MSB first, 8-bit frames, full duplex. Samples MOSI on SCK rising and updates MISO on SCK falling, so MISO is stable when the master samples it.
- Local side: a one-byte transmit holding register with a load handshake, and a receive byte port with a one-cycle valid pulse.

Parameters:
SS_ID, 2'd1, SS bus code that selects this responder; 2'd0 means bus idle and must not be used.
SYNC_STAGES, 0, extra flops on SCK/MOSI/SS before edge detection. Use 0 when the master shares Clk_i, 2 for an asynchronous master.

Ports:
Clk_i  input  1  system clock, all state on rising edge
Rst_i  input  1  asynchronous, active-high reset
sck_i  input  1  SPI clock from master, idles low
mosi_i  input  1  serial data from master
ss_i  input  2  select code from master
miso_o  output  1  serial data to master
tx_data_i  input  8  byte to send in a following frame
tx_load_i  input  1  strobe: write tx_data_i into holding register
tx_full_o  output  1  holding register occupied
rx_data_o  output  8  last received byte
rx_valid_o  output  1  one-cycle pulse, rx_data_o updated
tx_underrun_o  output  1  one-cycle pulse, frame started with empty holding register
tx_overflow_o  output  1  one-cycle pulse, tx_load_i while tx_full_o=1

Behaviour:
- Reset (async, Rst_i=1): all outputs 0, shift registers 0, bitcnt=0, state IDLE, sck_q=0. Reset mid-frame discards the frame; no rx_valid_o.
- Signals: sel = (ss_s == SS_ID); rise = sck_s & ~sck_q; fall = ~sck_s & sck_q; sck_q is sck_s delayed one cycle. ss_s and sck_s are the sync-chain outputs.
- Timing constraint: MISO updates SYNC_STAGES+1 cycles after SCK falls. The master half-period must exceed SYNC_STAGES+1 cycles. With SYNC_STAGES=0 and master CLKDIV=4 this holds.
- FSM states: IDLE, ACTIVE.
- IDLE -> ACTIVE on the first cycle sel=1 ("frame load"):
  - txsh <= hold if tx_full_o, else 8'h00 with a tx_underrun_o pulse.
  - tx_full_o clears. bitcnt <= 0.
- In ACTIVE:
  - On rise: rxsh <= {rxsh[6:0], mosi_s}; bitcnt <= bitcnt+1.
  - When bitcnt reaches 8 (registered): rx_data_o <= rxsh and rx_valid_o=1 in the next cycle (2 cycles after the 8th rise is detected), single cycle.
  - On fall with bitcnt<8: txsh <= {txsh[6:0],1'b0}.
  - On fall with bitcnt==8: frame load as above (back-to-back frame), bitcnt <= 0.
- ACTIVE -> IDLE whenever sel=0. Partial byte discarded, bitcnt <= 0, no rx_valid_o. A completed byte whose rx_valid_o is pending is still delivered.
- miso_o = txsh[7] while ACTIVE, 0 in IDLE (no tristate).
- tx_load_i with tx_full_o=0: hold <= tx_data_i, tx_full_o=1 next cycle.
- tx_load_i with tx_full_o=1: ignored, tx_overflow_o pulse.
- tx_load_i in the same cycle as a frame load: the frame takes the old hold (or underruns), and the new byte is stored, so tx_full_o stays 1.
- rise and fall never occur in the same cycle. SCK edges while IDLE are ignored. An SS code change between two non-zero codes deselects if it no longer equals SS_ID.
- Counters: bitcnt is 4 bits, range 0..8, never wraps past 8.

Test Plan:
- Reset: Rst_i pulsed mid-frame -> all outputs 0 in the same cycle, no rx_valid_o after release, next frame correct.
- Single exchange: tx_load 8'hA5, master sends 8'h3C to SS_ID -> rx_data_o=8'h3C with one rx_valid_o pulse, master Rcvd=8'hA5, tx_full_o 1->0 at select.
- Back-to-back: load 8'h81, master sends 8'h12 then 8'h34 with SS held; load 8'h7E between frames -> rx 8'h12 then 8'h34, master receives 8'h81 then 8'h7E.
- Underrun/overflow: select with empty holding register -> miso 8'h00, one tx_underrun_o pulse. Two tx_load_i with no frame (8'h11, 8'h22) -> tx_overflow_o on the second, 8'h11 sent.
- Not selected: master addresses ss=2'd2 (SS_ID=1) and sends 8'hFF -> miso_o stays 0, no rx_valid_o, tx_full_o unchanged.
- Abort: ss drops to 0 after 5 SCK rises -> no rx_valid_o. Reselect with 8'hC3 -> rx_data_o=8'hC3, bit alignment correct.
